// File: rtl/riscv_pkg.sv
// Shared core types: memory access modes (funct3) and the LSU's latched request.
package riscv_pkg;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } mem_mode_t;

    typedef struct packed {
        logic       wen;
        logic [2:0] mode;
        logic [1:0] off;
    } lsu_req_t;

    // Legal funct3 for the direction, and naturally aligned for the access size.
    function automatic logic lsu_req_ok(input logic wen, input logic [2:0] mode,
                                        input logic [1:0] off);
        logic legal;
        logic aligned;
        case (mode)
            3'b000, 3'b001, 3'b010: legal = 1'b1;
            3'b100, 3'b101:         legal = !wen;
            default:                legal = 1'b0;
        endcase
        case (mode[1:0])
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = !off[0];
            2'b10:   aligned = (off == 2'b00);
            default: aligned = 1'b0;
        endcase
        return legal && aligned;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Store lane replication / byte enables and load shift + extend, purely combinational.
module lsu_align
    import riscv_pkg::*;
(
    input  logic        wen,
    input  logic [2:0]  mode,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] word,
    output logic [31:0] lane_wdata,
    output logic [3:0]  be,
    output logic [31:0] load_data
);

    logic [31:0] shifted;
    logic [3:0]  be_st;

    always_comb begin
        shifted = word >> {off, 3'b000};
        case (mode[1:0])
            2'b00: begin
                lane_wdata = {4{wdata[7:0]}};
                be_st      = 4'b0001 << off;
            end
            2'b01: begin
                lane_wdata = {2{wdata[15:0]}};
                be_st      = 4'b0011 << off;
            end
            default: begin
                lane_wdata = wdata;
                be_st      = 4'b1111;
            end
        endcase
        be = wen ? be_st : 4'b1111;
        case (mode)
            LB:      load_data = {{24{shifted[7]}}, shifted[7:0]};
            LH:      load_data = {{16{shifted[15]}}, shifted[15:0]};
            LBU:     load_data = {24'd0, shifted[7:0]};
            LHU:     load_data = {16'd0, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one access per instruction over a valid/ack word bus, stalling the core until done.
module lsu
    import riscv_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_wen,
    input  logic [2:0]        req_mode,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              stall,
    output logic [31:0]       rdata,
    output logic              rdata_valid,
    output logic              misalign,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [31:0]       bus_wdata,
    output logic [3:0]        bus_be,
    input  logic              bus_ack,
    input  logic [31:0]       bus_rdata
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} lsu_state_t;

    lsu_state_t  state;
    lsu_req_t    cur;
    logic        al_wen;
    logic [2:0]  al_mode;
    logic [1:0]  al_off;
    logic [31:0] lane_wdata;
    logic [31:0] load_data;
    logic [3:0]  be;

    // The aligner sees the live request while accepting and the latched one afterwards.
    assign al_wen  = (state == IDLE) ? req_wen        : cur.wen;
    assign al_mode = (state == IDLE) ? req_mode       : cur.mode;
    assign al_off  = (state == IDLE) ? req_addr[1:0]  : cur.off;

    lsu_align u_align (
        .wen        (al_wen),
        .mode       (al_mode),
        .off        (al_off),
        .wdata      (req_wdata),
        .word       (bus_rdata),
        .lane_wdata (lane_wdata),
        .be         (be),
        .load_data  (load_data)
    );

    assign stall = ((state == IDLE) && req_valid) || (state == BUSY);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cur         <= '0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            misalign    <= 1'b0;
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= '0;
            bus_wdata   <= '0;
            bus_be      <= '0;
        end else begin
            rdata_valid <= 1'b0;
            misalign    <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (lsu_req_ok(req_wen, req_mode, req_addr[1:0])) begin
                            cur       <= '{wen: req_wen, mode: req_mode, off: req_addr[1:0]};
                            bus_req   <= 1'b1;
                            bus_we    <= req_wen;
                            bus_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                            bus_wdata <= req_wen ? lane_wdata : 32'd0;
                            bus_be    <= be;
                            state     <= BUSY;
                        end else begin
                            misalign <= 1'b1;
                            state    <= DONE;
                        end
                    end
                end
                BUSY: begin
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        bus_we  <= 1'b0;
                        if (!cur.wen) begin
                            rdata       <= load_data;
                            rdata_valid <= 1'b1;
                        end
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Randomized scoreboard bench for lsu against a byte-addressed memory reference model.
module tb_lsu;

    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid, req_wen;
    logic [2:0]        req_mode;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              stall, rdata_valid, misalign;
    logic [31:0]       rdata;
    logic              bus_req, bus_we, bus_ack;
    logic [ADDR_W-1:0] bus_addr;
    logic [31:0]       bus_wdata, bus_rdata;
    logic [3:0]        bus_be;

    always #5 clk = ~clk;

    lsu #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_wen(req_wen), .req_mode(req_mode),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid), .misalign(misalign),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_be(bus_be),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    // kind: 0 load result, 1 store, 2 rejected access
    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        we;
        logic [31:0] rdata;
    } exp_t;

    exp_t        q[$];
    int          compared = 0, mismatched = 0;
    logic [7:0]  bmem [64];
    logic [31:0] wmem [16];
    bit          resp_en = 0, mon_en = 0;
    int          force_lat = -1, last_lat = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        compared++;
        mismatched++;
        $display("FAIL %s: got unexpected event want none", name);
    endtask

    function automatic int size_of(input logic [2:0] m);
        case (m[1:0])
            2'd0:    return 1;
            2'd1:    return 2;
            2'd2:    return 4;
            default: return 0;
        endcase
    endfunction

    task automatic set_word(input int a, input logic [31:0] w);
        for (int b = 0; b < 4; b++) bmem[(a + b) % 64] = w[8*b +: 8];
        wmem[(a % 64) / 4] = w;
    endtask

    // Reference: little-endian byte memory, sizes 1/2/4, natural alignment, arithmetic extension.
    task automatic model(input logic wen, input logic [2:0] mode, input logic [31:0] a,
                         input logic [31:0] wd, output int kind);
        exp_t   e;
        int     n, off;
        bit     legal;
        longint v;
        n     = size_of(mode);
        off   = int'(a[5:0]);
        legal = (n != 0) && !(wen && mode[2]) && (mode != 3'b110);
        if (legal) legal = (off % n) == 0;
        e = '{kind: 2, addr: 0, wdata: 0, be: 0, we: 0, rdata: 0};
        if (legal) begin
            e.addr = a & ~32'h3;
            e.we   = wen;
            if (wen) begin
                e.kind  = 1;
                e.be    = 4'(((1 << n) - 1) << (off % 4));
                e.wdata = (n == 1) ? wd[7:0] * 32'h01010101 :
                          (n == 2) ? wd[15:0] * 32'h00010001 : wd;
                for (int k = 0; k < n; k++) bmem[off + k] = 8'(wd >> (8 * k));
            end else begin
                e.kind = 0;
                e.be   = 4'hF;
                v = 0;
                for (int k = 0; k < n; k++) v = v | (longint'(bmem[off + k]) << (8 * k));
                if (!mode[2] && n < 4 && v >= (longint'(1) << (8 * n - 1)))
                    v = v - (longint'(1) << (8 * n));
                e.rdata = 32'(v);
            end
        end
        q.push_back(e);
        kind = e.kind;
    endtask

    // Presents one instruction and holds it until the unit releases stall.
    task automatic issue(input logic wen, input logic [2:0] mode, input int a, input logic [31:0] wd);
        int kind, cyc;
        model(wen, mode, 32'h100 + 32'(a), wd, kind);
        req_valid = 1; req_wen = wen; req_mode = mode;
        req_addr = 32'h100 + 32'(a); req_wdata = wd;
        cyc = 0;
        while (1) begin
            @(posedge clk); #1;
            cyc++;
            if (!stall) break;
            if (cyc > 60) begin
                flag("timeout");
                break;
            end
        end
        check("stall_cycles", cyc, (kind == 2) ? 1 : 2 + last_lat);
        @(posedge clk); #1;
        req_valid = 0;
    endtask

    // Memory slave: random latency, word memory with byte enables, stray acks when idle.
    initial begin
        int lat, idx;
        bus_ack = 0; bus_rdata = 0;
        forever begin
            @(negedge clk);
            bus_ack = 0;
            if (!resp_en) continue;
            if (bus_req) begin
                lat = (force_lat >= 0) ? force_lat : $urandom_range(0, 3);
                last_lat = lat;
                repeat (lat) @(negedge clk);
                idx = int'(bus_addr[5:2]);
                if (bus_we)
                    for (int b = 0; b < 4; b++)
                        if (bus_be[b]) wmem[idx][8*b +: 8] = bus_wdata[8*b +: 8];
                bus_rdata = wmem[idx];
                bus_ack = 1;
            end else if (!stall && $urandom_range(0, 3) == 0) begin
                bus_ack = 1;
                bus_rdata = $urandom;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT shows a bus request, completion or error.
    initial begin
        bit          prev_req = 0, prev_we = 0;
        logic [31:0] s_addr, s_wdata;
        logic [3:0]  s_be;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (bus_req && !prev_req) begin
                    if (q.size() == 0 || q[0].kind == 2) flag("bus_req_unexpected");
                    else begin
                        check("bus_addr", bus_addr, q[0].addr);
                        check("bus_we", 32'(bus_we), 32'(q[0].we));
                        check("bus_be", 32'(bus_be), 32'(q[0].be));
                        if (q[0].we) check("bus_wdata", bus_wdata, q[0].wdata);
                    end
                    s_addr = bus_addr; s_wdata = bus_wdata; s_be = bus_be;
                end else if (bus_req) begin
                    check("bus_hold", {bus_addr[27:0], bus_be}, {s_addr[27:0], s_be});
                    check("bus_hold_wdata", bus_wdata, s_wdata);
                end
                if (!bus_req && prev_req && prev_we) begin
                    if (q.size() != 0 && q[0].kind == 1) void'(q.pop_front());
                    else flag("store_done_unexpected");
                end
                if (rdata_valid) begin
                    if (q.size() != 0 && q[0].kind == 0) begin
                        check("rdata", rdata, q[0].rdata);
                        void'(q.pop_front());
                    end else flag("rdata_valid_unexpected");
                end
                if (misalign) begin
                    if (q.size() != 0 && q[0].kind == 2) void'(q.pop_front());
                    else flag("misalign_unexpected");
                end
            end
            prev_req = bus_req;
            prev_we  = bus_we;
        end
    end

    initial begin
        int m, gap;
        req_valid = 0; req_wen = 0; req_mode = 0; req_addr = 0; req_wdata = 0;
        for (int i = 0; i < 64; i++) bmem[i] = 8'($urandom);
        for (int i = 0; i < 16; i++) wmem[i] = {bmem[4*i+3], bmem[4*i+2], bmem[4*i+1], bmem[4*i]};
        rst = 1;
        #3 rst = 0;
        #20;
        check("reset_state", {28'd0, stall, bus_req, rdata_valid, misalign}, 32'd0);
        check("reset_rdata", rdata, 32'd0);
        check("reset_bus", {bus_addr[27:0], bus_be}, 32'd0);
        @(negedge clk); rst = 1;
        resp_en = 1; mon_en = 1;
        @(posedge clk); #1;

        set_word(32'h100, 32'hDEADBEEF);
        force_lat = 3; issue(0, 3'b010, 32'h00, 0);
        set_word(32'h100, 32'h80FF0000);
        force_lat = 0;
        issue(0, 3'b000, 32'h03, 0);
        issue(0, 3'b100, 32'h03, 0);
        issue(0, 3'b101, 32'h02, 0);
        force_lat = 1; issue(1, 3'b001, 32'h06, 32'h1234ABCD);
        issue(0, 3'b010, 32'h01, 0);
        issue(0, 3'b011, 32'h00, 0);
        issue(1, 3'b100, 32'h00, 32'h55);
        force_lat = 0;
        issue(0, 3'b010, 32'h04, 0);
        issue(0, 3'b010, 32'h08, 0);

        force_lat = -1;
        for (int t = 0; t < 300; t++) begin
            m = $urandom_range(0, 9);
            if (m > 7) m = 2;
            issue(1'($urandom_range(0, 1)), 3'(m), $urandom_range(0, 63), $urandom);
            gap = $urandom_range(0, 2);
            repeat (gap) begin @(posedge clk); #1; end
        end
        repeat (5) @(posedge clk);
        #1 check("queue_drained", q.size(), 0);

        // Reset in the middle of a load, then an ack after release.
        mon_en = 0; resp_en = 0;
        @(posedge clk); #1;
        req_valid = 1; req_wen = 0; req_mode = 3'b010; req_addr = 32'h110;
        @(posedge clk); #1;
        check("busy_req", {30'd0, bus_req, stall}, 32'd3);
        #2 rst = 0; req_valid = 0;
        #1 check("reset_mid", {29'd0, bus_req, stall, rdata_valid}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1;
        @(negedge clk); bus_ack = 1; bus_rdata = 32'hCAFEF00D;
        @(negedge clk); bus_ack = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_reset_quiet", {28'd0, stall, bus_req, rdata_valid, misalign}, 32'd0);
        end
        check("post_reset_rdata", rdata, 32'd0);

        mon_en = 1; resp_en = 1;
        @(posedge clk); #1;
        issue(0, 3'b010, 32'h10, 0);
        repeat (3) @(posedge clk);
        #1 check("final_drained", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
